// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared types and constants for the multicycle FP divide arbiter
// Holds the controller state enum, the canned quiet NaN, response flag bit
// positions and the operand class used by the special-case screen.
package fp_div_pkg;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Bit positions inside rsp_flags = {invalid, div_by_zero, overflow, underflow}
  localparam int FLG_INV = 3;
  localparam int FLG_DZ  = 2;
  localparam int FLG_OF  = 1;
  localparam int FLG_UF  = 0;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

  // Denormals (exponent 0) are flushed and classed as zero.
  function automatic fp_class_t fp_class(input logic [31:0] v);
    if (v[30:23] == 8'h00)      return ZERO;
    else if (v[30:23] != 8'hFF) return NORM;
    else if (v[22:0] == 23'h0)  return INF;
    else                        return NAN;
  endfunction

  function automatic logic [31:0] fp_inf(input logic s);
    return {s, 8'hFF, 23'h0};
  endfunction

endpackage

// File: rtl/fp_div_classify.sv
// rtl/fp_div_classify.sv - combinational special-case and exponent-range screen for x / b
// Ports:
//   x, b    : single-precision dividend and divisor
//   special : result is fully determined here, the divider is not needed
//   z       : canned result (valid when special)
//   flags   : {invalid, div_by_zero, overflow, underflow} for the canned result
//   sign    : quotient sign x[31] ^ b[31]
module fp_div_classify
  import fp_div_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] b,
  output logic        special,
  output logic [31:0] z,
  output logic [3:0]  flags,
  output logic        sign
);

  fp_class_t        cx;
  fp_class_t        cb;
  logic signed [9:0] e;

  assign cx   = fp_class(x);
  assign cb   = fp_class(b);
  assign sign = x[31] ^ b[31];
  // Biased result exponent before normalisation; 10 bits signed covers -128..382.
  assign e    = $signed({2'b00, x[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;

  always_comb begin
    special = 1'b1;
    z       = '0;
    flags   = '0;
    if (cx == NAN || cb == NAN || (cx == ZERO && cb == ZERO) || (cx == INF && cb == INF)) begin
      z              = QNAN;
      flags[FLG_INV] = 1'b1;
    end else if (cx == INF) begin
      z = fp_inf(sign);
    end else if (cb == ZERO) begin
      z             = fp_inf(sign);
      flags[FLG_DZ] = 1'b1;
    end else if (cx == ZERO || cb == INF) begin
      z = {sign, 31'b0};
    end else if (e >= 10'sd256) begin
      z             = fp_inf(sign);
      flags[FLG_OF] = 1'b1;
    end else if (e <= 10'sd0) begin
      z             = {sign, 31'b0};
      flags[FLG_UF] = 1'b1;
    end else begin
      special = 1'b0;
    end
  end

endmodule

// File: rtl/fp_div_arbiter.sv
// rtl/fp_div_arbiter.sv - round-robin arbiter and multicycle controller for one shared FP divider
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake; ready is one-hot and only in IDLE
//   req_x, req_b         : packed per-requester dividend/divisor, 32 bits each
//   rsp_valid/rsp_ready  : response handshake, rsp_* held while stalled
//   rsp_id, rsp_z        : owning requester and quotient
//   rsp_flags            : {invalid, div_by_zero, overflow, underflow}
//   div_x, div_b, div_z  : registered operands to and result from the external divider
module fp_div_arbiter
  import fp_div_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int DIV_CYCLES = 3,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [32*N_REQ-1:0]   req_x,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_z,
  output logic [3:0]            rsp_flags,
  output logic [31:0]           div_x,
  output logic [31:0]           div_b,
  input  logic [31:0]           div_z
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              sign_q;

  logic              gnt_any;
  logic [ID_W-1:0]   gnt_idx;
  logic [31:0]       sel_x;
  logic [31:0]       sel_b;
  logic              cls_special;
  logic [31:0]       cls_z;
  logic [3:0]        cls_flags;
  logic              cls_sign;

  // Scan offsets from the highest down so the last hit is the nearest index at or after rr_ptr.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_valid[idx[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[ID_W-1:0];
      end
    end
  end

  assign req_ready = (state == S_IDLE && gnt_any) ? (N_REQ'(1) << gnt_idx) : '0;
  assign sel_x     = req_x[32*gnt_idx +: 32];
  assign sel_b     = req_b[32*gnt_idx +: 32];

  fp_div_classify u_classify (
    .x       (sel_x),
    .b       (sel_b),
    .special (cls_special),
    .z       (cls_z),
    .flags   (cls_flags),
    .sign    (cls_sign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_z     <= '0;
      rsp_flags <= '0;
      div_x     <= '0;
      div_b     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            div_x  <= sel_x;
            div_b  <= sel_b;
            rsp_id <= gnt_idx;
            sign_q <= cls_sign;
            rr_ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            if (cls_special) begin
              rsp_z     <= cls_z;
              rsp_flags <= cls_flags;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              cnt   <= CNT_W'(DIV_CYCLES - 1);
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          // div_x/div_b stay untouched here: the divider is a multicycle path.
          if (cnt == '0) begin
            rsp_valid <= 1'b1;
            state     <= S_RESP;
            if (div_z[30:23] == 8'hFF) begin
              rsp_z     <= fp_inf(sign_q);
              rsp_flags <= 4'(1 << FLG_OF);
            end else if (div_z[30:23] == 8'h00) begin
              rsp_z     <= {sign_q, 31'b0};
              rsp_flags <= 4'(1 << FLG_UF);
            end else begin
              rsp_z     <= div_z;
              rsp_flags <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb/tb_fp_div_arbiter.sv - directed self-checking bench for fp_div_arbiter
module tb_fp_div_arbiter;

  localparam int N_REQ      = 2;
  localparam int DIV_CYCLES = 3;
  localparam int ID_W       = 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_x;
  logic [32*N_REQ-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [31:0]         rsp_z;
  logic [3:0]          rsp_flags;
  logic [31:0]         div_x;
  logic [31:0]         div_b;
  logic [31:0]         div_z;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_div_arbiter #(.N_REQ(N_REQ), .DIV_CYCLES(DIV_CYCLES), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_z     (rsp_z),
    .rsp_flags (rsp_flags),
    .div_x     (div_x),
    .div_b     (div_b),
    .div_z     (div_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at a falling edge with the DUT idle; one requester, rsp_ready held high.
  task automatic run_op(input string tag, input int who, input logic [31:0] x,
                        input logic [31:0] b, input logic [31:0] dz, input int exp_lat,
                        input logic [31:0] exp_z, input logic [3:0] exp_f);
    int lat;
    div_z               = dz;
    req_x[32*who +: 32] = x;
    req_b[32*who +: 32] = b;
    req_valid           = N_REQ'(1) << who;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(1 << who));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req_valid = '0;
        chk({tag, "_div_x"}, div_x, x);
        chk({tag, "_div_b"}, div_b, b);
      end
    end while (!rsp_valid && lat < 20);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_z"}, rsp_z, exp_z);
    chk({tag, "_flags"}, 32'(rsp_flags), 32'(exp_f));
    chk({tag, "_id"}, 32'(rsp_id), 32'(who));
    @(negedge clk);
    chk({tag, "_idle"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    div_z     = '0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_z", rsp_z, 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_div_x", div_x, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal op: 6.0 / 2.0, response DIV_CYCLES edges after the accept edge.
    run_op("norm_6_2", 0, 32'h40C00000, 32'h40000000, 32'h40400000, DIV_CYCLES + 1, 32'h40400000, 4'b0000);
    run_op("dz_pos", 1, 32'h3F800000, 32'h00000000, 32'h0, 1, 32'h7F800000, 4'b0100);

    // Both requesting continuously, rr_ptr is 0 here: grants 0,1,0,1, one per DIV_CYCLES+2 cycles.
    div_z     = 32'h3F800000;
    req_x     = {2{32'h3F800000}};
    req_b     = {2{32'h3F800000}};
    req_valid = 2'b11;
    #1;
    chk("alt_first_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      lat = 0;
      while (!rsp_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("alt%0d_gap", k), 32'(lat), 32'(DIV_CYCLES + 1));
      chk($sformatf("alt%0d_id", k), 32'(rsp_id), 32'(k % 2));
      chk($sformatf("alt%0d_z", k), rsp_z, 32'h3F800000);
      if (k == 3) req_valid = '0;
      @(negedge clk);
    end

    run_op("dz_neg", 0, 32'h3F800000, 32'h80000000, 32'h0, 1, 32'hFF800000, 4'b0100);
    run_op("zero_zero", 1, 32'h00000000, 32'h00000000, 32'h0, 1, 32'h7FC00000, 4'b1000);
    run_op("nan_x", 0, 32'h7FC00001, 32'h3F800000, 32'h0, 1, 32'h7FC00000, 4'b1000);
    run_op("ovf_range", 1, 32'h7F000000, 32'h00800000, 32'h0, 1, 32'h7F800000, 4'b0010);
    run_op("unf_range", 0, 32'h00800000, 32'h7F000000, 32'h0, 1, 32'h00000000, 4'b0001);
    run_op("inf_x", 1, 32'h7F800000, 32'h3F800000, 32'h0, 1, 32'h7F800000, 4'b0000);
    run_op("divz_unf", 0, 32'h3F800000, 32'h40000000, 32'h00000001, DIV_CYCLES + 1, 32'h00000000, 4'b0001);
    run_op("divz_ovf", 1, 32'hBF800000, 32'h3F800000, 32'h7F800000, DIV_CYCLES + 1, 32'hFF800000, 4'b0010);

    // Stalled response: rsp_* held, no grants while requester 1 waits.
    rsp_ready       = 1'b0;
    div_z           = 32'h3F800000;
    req_x[31:0]     = 32'h3F800000;
    req_b[31:0]     = 32'h3F800000;
    req_valid       = 2'b01;
    @(negedge clk);
    req_valid = 2'b11;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("stall%0d_z", k), rsp_z, 32'h3F800000);
      chk($sformatf("stall%0d_id", k), 32'(rsp_id), 32'd0);
      chk($sformatf("stall%0d_ready", k), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", 32'(rsp_valid), 32'd0);
    chk("stall_idle_grant", 32'(req_ready), 32'd2);
    @(negedge clk);
    chk("stall_calc_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("stall_next_id", 32'(rsp_id), 32'd1);
    chk("stall_next_z", rsp_z, 32'h3F800000);
    @(negedge clk);

    // Reset during CALC with rr_ptr at 1: everything clears, pointer restarts at 0.
    div_z       = 32'h40400000;
    req_x       = {2{32'h40C00000}};
    req_b       = {2{32'h40000000}};
    req_valid   = 2'b01;
    @(negedge clk);
    req_valid = '0;
    chk("pre_rst_div_x", div_x, 32'h40C00000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_div_x", div_x, 32'd0);
    chk("midrst_div_b", div_b, 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_id", 32'(rsp_id), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("no_stale%0d", k), 32'(rsp_valid), 32'd0);
    end
    req_valid = 2'b11;
    #1;
    chk("post_rst_ptr_grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("post_rst_latency", 32'(lat), 32'(DIV_CYCLES + 1));
    chk("post_rst_id", 32'(rsp_id), 32'd0);
    chk("post_rst_z", rsp_z, 32'h40400000);
    chk("post_rst_flags", 32'(rsp_flags), 32'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
